mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 result mux between four requesters.
- Drives the mux select pair {sel1,sel2} and a one-hot grant back to the requesters.
- Enforces a maximum hold time so no requester can starve the others.
- Sits between the datapath requesters (ALU, load unit, branch unit, immediate path) and the shared result mux.

Parameters:
MAX_HOLD, 8, maximum consecutive GRANT cycles for one owner while another request is pending (legal range 2..255)
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  4  request per requester; bit i = requester i, level-sensitive
gnt  output  4  one-hot grant; all-zero when no owner
sel1  output  1  mux select MSB (owner index bit 1)
sel2  output  1  mux select LSB (owner index bit 0)
busy  output  1  high while in GRANT
preempt  output  1  one-cycle pulse when an owner is forcibly released by timeout

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk; rst is sampled only at the edge.
- Reset values:
  - gnt=4'b0000, sel1=0, sel2=0, busy=0, preempt=0
  - state=IDLE, hold counter=0, last-owner pointer=3, so requester 0 has first priority after reset.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req != 0, pick the winner by round-robin, searching from (last+1) mod 4 upward with wrap.
  - Next cycle: gnt = onehot(winner), {sel1,sel2} = winner, busy=1, state=GRANT, counter=0. Latency from req to gnt is 1 cycle.
  - If req == 0, stay in IDLE with outputs at their reset values.
- GRANT:
  - Owner holds the grant while req[owner]=1. The counter increments each cycle, saturating at MAX_HOLD-1.
  - Owner drops req[owner]: next cycle gnt=0, busy=0, state=TURN, last=owner.
  - Counter == MAX_HOLD-1 and any other req bit set: forced release. Next cycle gnt=0, busy=0, preempt=1 for exactly that cycle, state=TURN, last=owner.
  - Counter == MAX_HOLD-1 and no other req: owner keeps the grant, counter reloads to 0, no preempt.
  - Owner drop and timeout in the same cycle: treat as a normal release, preempt=0.
- TURN:
  - One dead cycle: gnt=0, sel holds its previous value, busy=0.
  - Next state is IDLE. A pending request gets its grant 2 cycles after release; this is the mux turnaround guarantee.
- Select lines change only on the transition into GRANT, never while gnt is all-zero, except at reset.
- gnt is always one-hot or zero. {sel1,sel2} always equals the index of the set gnt bit when busy=1.
- Simultaneous requests: the lowest index at or after (last+1) mod 4 wins; there is no fixed priority.
- Reset mid-GRANT: rst overrides everything. Outputs return to reset values on the same edge and last=3.
- Requests are not latched. A req pulse that falls before IDLE samples it is lost; requesters must hold req until granted.
- Any unreachable state encoding recovers to IDLE with outputs cleared.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_TURN=2'd2
  - NUM_REQ=4
  - helper function for one-hot encoding of a 2-bit index
- Sub-module rr_pick (combinational): inputs req[3:0] and last[1:0]; outputs winner[1:0] and any. It isolates the wrap-around search for separate unit test.
- The FSM, counter and output registers stay in mux_rr_arbiter.
- Connect sel1/sel2 directly to the existing 4:1 result mux.

Test Plan:
1. Reset release, then req=0001 at cycle 0 -> cycle 1: gnt=0001, sel1=0, sel2=0, busy=1. Drop req at cycle 3 -> cycle 4: gnt=0, TURN; cycle 5 IDLE.
2. req=1111 held continuously, MAX_HOLD=8 -> grants rotate 0,1,2,3,0. Each owner gets 8 GRANT cycles then preempt=1 for one cycle. {sel1,sel2} follows 00,01,10,11.
3. Only req=0100 held for 30 cycles -> gnt=0100 and sel=10 are continuous with no gaps and preempt never asserts.
4. After owner 3 releases, apply req=1001 -> requester 0 wins (wrap-around from last=3). Grant arrives 2 cycles after the release.
5. rst=1 asserted mid-GRANT with owner 2 at counter=5 -> next edge: gnt=0, sel=00, busy=0. Then req=0110 -> requester 1 wins (last reset to 3, so search starts at 0).
6. Owner 1 drops req exactly on the timeout cycle while req[2]=1 -> normal release with preempt=0, then requester 2 is granted after TURN.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin result-mux arbiter.
//   state_t  : FSM state encoding (IDLE / GRANT / TURN)
//   NUM_REQ  : number of requesters sharing the 4:1 result mux
//   onehot2  : 2-bit index to 4-bit one-hot grant vector
package mux_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot2(input logic [1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the datapath requesters and the arbiter.
//   req     : level request per requester (bit i = requester i)
//   gnt     : one-hot grant, zero when nobody owns the mux
//   sel1    : result mux select MSB (owner index bit 1)
//   sel2    : result mux select LSB (owner index bit 0)
//   busy    : a grant is currently active
//   preempt : one-cycle pulse when the owner was released by timeout
// Handshake: a requester raises req[i] and must hold it until gnt[i] is
// seen; it keeps ownership for as long as it keeps req[i] high (subject to
// the hold limit) and gives the mux back by dropping req[i]. Requests are
// not latched, so a request dropped before it is granted is simply lost.
// The master modport is the requester side, slave is the arbiter side.
interface mux_rr_arbiter_if;
  import mux_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               sel1;
  logic               sel2;
  logic               busy;
  logic               preempt;

  modport master (
    output req,
    input  gnt, sel1, sel2, busy, preempt
  );

  modport slave (
    input  req,
    output gnt, sel1, sel2, busy, preempt
  );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin winner search.
//   req    : request vector
//   last   : index of the previous owner
//   winner : first requester found searching from (last+1) mod 4 with wrap
//   any    : at least one request is present (winner is valid)
module mux_rr_arbiter_rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         winner,
  output logic               any
);

  logic [1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest requester
  // after 'last' is the final assignment. Offset 4 wraps to 'last' itself,
  // which makes the previous owner the lowest-priority candidate.
  always_comb begin
    winner = '0;
    idx    = '0;
    any    = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last + k[1:0];
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 result mux.
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset
//   bus       : slave side of mux_rr_arbiter_if (req in; gnt, sel1, sel2,
//               busy, preempt out)
//   dbg_state : current FSM state
// A winner granted from IDLE owns the mux while it holds its request. After
// MAX_HOLD consecutive grant cycles with another request pending the owner
// is forced off (preempt pulse). Every release passes through one TURN
// cycle and one IDLE cycle so the mux select settles before the next owner.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  mux_rr_arbiter_if.slave     bus,
  output state_t              dbg_state
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         last_q,  last_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic               busy_q,  busy_d;
  logic               pre_q,   pre_d;

  logic [1:0]         winner;
  logic               any_req;
  logic               others;

  mux_rr_arbiter_rr_pick u_rr_pick (
    .req    (bus.req),
    .last   (last_q),
    .winner (winner),
    .any    (any_req)
  );

  assign others = (bus.req & ~onehot2(owner_q)) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      pre_q   <= pre_d;
    end
  end

  // owner_q doubles as the mux select; it only changes on entry to GRANT,
  // so the select stays put through TURN and IDLE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    busy_d  = 1'b0;
    pre_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANT;
          owner_d = winner;
          cnt_d   = '0;
          gnt_d   = onehot2(winner);
          busy_d  = 1'b1;
        end
      end
      ST_GRANT: begin
        gnt_d  = onehot2(owner_q);
        busy_d = 1'b1;
        if (!bus.req[owner_q]) begin
          // Voluntary release wins over a coincident timeout.
          state_d = ST_TURN;
          last_d  = owner_q;
          cnt_d   = '0;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (others) begin
            state_d = ST_TURN;
            last_d  = owner_q;
            gnt_d   = '0;
            busy_d  = 1'b0;
            pre_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel1    = owner_q[1];
  assign bus.sel2    = owner_q[0];
  assign bus.busy    = busy_q;
  assign bus.preempt = pre_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
  import mux_rr_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;

  always #5 clk = ~clk;

  mux_rr_arbiter_if bus ();

  mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  // Expected word per cycle: {state[1:0], gnt[3:0], sel[1:0], busy, preempt}
  logic [9:0] exp_q[$];
  logic [4:0] stim_q[$];   // {rst, req[3:0]}
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [9:0] ew(input logic [1:0] st, input logic [3:0] g,
                                    input logic [1:0] s, input logic b,
                                    input logic p);
    return {st, g, s, b, p};
  endfunction

  function automatic logic [9:0] observed();
    return {2'(dbg_state), bus.gnt, bus.sel1, bus.sel2, bus.busy, bus.preempt};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic plan(input logic rs, input logic [3:0] r, input logic [9:0] e);
    stim_q.push_back({rs, r});
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic [4:0] s);
    rst     = s[4];
    bus.req = s[3:0];
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [9:0] got, e;
    plan(1'b1, 4'b0000, ew(ST_IDLE, 4'b0000, 2'b00, 1'b0, 1'b0));
    plan(1'b1, 4'b1111, ew(ST_IDLE, 4'b0000, 2'b00, 1'b0, 1'b0));
    plan(1'b0, 4'b0000, ew(ST_IDLE, 4'b0000, 2'b00, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      tick(stim_q.pop_front());
      got = observed();
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset: {st,gnt,sel,busy,pre} got %b want %b", got, e);
      end
    end
  endtask

  // Single requester: 1-cycle grant latency, release through TURN and IDLE.
  task automatic test_basic();
    logic [9:0] got, e;
    for (int i = 0; i < 3; i++)
      plan(1'b0, 4'b0001, ew(ST_GRANT, 4'b0001, 2'b00, 1'b1, 1'b0));
    plan(1'b0, 4'b0000, ew(ST_TURN, 4'b0000, 2'b00, 1'b0, 1'b0));
    plan(1'b0, 4'b0000, ew(ST_IDLE, 4'b0000, 2'b00, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      tick(stim_q.pop_front());
      got = observed();
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL basic: {st,gnt,sel,busy,pre} got %b want %b", got, e);
      end
    end
  endtask

  // All four request continuously: 8 grant cycles each, then preempt.
  task automatic test_rotate_preempt();
    logic [9:0] got, e;
    logic [1:0] kk;
    plan(1'b1, 4'b1111, ew(ST_IDLE, 4'b0000, 2'b00, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) begin
      kk = 2'(k);
      for (int c = 0; c < 8; c++)
        plan(1'b0, 4'b1111, ew(ST_GRANT, onehot2(kk), kk, 1'b1, 1'b0));
      plan(1'b0, 4'b1111, ew(ST_TURN, 4'b0000, kk, 1'b0, 1'b1));
      plan(1'b0, 4'b1111, ew(ST_IDLE, 4'b0000, kk, 1'b0, 1'b0));
    end
    plan(1'b0, 4'b1111, ew(ST_GRANT, 4'b0001, 2'b00, 1'b1, 1'b0));
    plan(1'b0, 4'b0000, ew(ST_TURN, 4'b0000, 2'b00, 1'b0, 1'b0));
    plan(1'b0, 4'b0000, ew(ST_IDLE, 4'b0000, 2'b00, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      tick(stim_q.pop_front());
      got = observed();
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL rotate: {st,gnt,sel,busy,pre} got %b want %b", got, e);
      end
    end
  endtask

  // Lone requester past the hold limit keeps the grant without gaps.
  task automatic test_lone_hold();
    logic [9:0] got, e;
    for (int i = 0; i < 30; i++)
      plan(1'b0, 4'b0100, ew(ST_GRANT, 4'b0100, 2'b10, 1'b1, 1'b0));
    plan(1'b0, 4'b0000, ew(ST_TURN, 4'b0000, 2'b10, 1'b0, 1'b0));
    plan(1'b0, 4'b0000, ew(ST_IDLE, 4'b0000, 2'b10, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      tick(stim_q.pop_front());
      got = observed();
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL lone_hold: {st,gnt,sel,busy,pre} got %b want %b", got, e);
      end
    end
  endtask

  // Owner 3 releases, req=1001 wraps to requester 0, then 3 gets its turn.
  task automatic test_wrap();
    logic [9:0] got, e;
    for (int i = 0; i < 3; i++)
      plan(1'b0, 4'b1000, ew(ST_GRANT, 4'b1000, 2'b11, 1'b1, 1'b0));
    plan(1'b0, 4'b0000, ew(ST_TURN, 4'b0000, 2'b11, 1'b0, 1'b0));
    plan(1'b0, 4'b1001, ew(ST_IDLE, 4'b0000, 2'b11, 1'b0, 1'b0));
    plan(1'b0, 4'b1001, ew(ST_GRANT, 4'b0001, 2'b00, 1'b1, 1'b0));
    plan(1'b0, 4'b1001, ew(ST_GRANT, 4'b0001, 2'b00, 1'b1, 1'b0));
    plan(1'b0, 4'b1000, ew(ST_TURN, 4'b0000, 2'b00, 1'b0, 1'b0));
    plan(1'b0, 4'b1000, ew(ST_IDLE, 4'b0000, 2'b00, 1'b0, 1'b0));
    plan(1'b0, 4'b1000, ew(ST_GRANT, 4'b1000, 2'b11, 1'b1, 1'b0));
    plan(1'b0, 4'b0000, ew(ST_TURN, 4'b0000, 2'b11, 1'b0, 1'b0));
    plan(1'b0, 4'b0000, ew(ST_IDLE, 4'b0000, 2'b11, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      tick(stim_q.pop_front());
      got = observed();
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL wrap: {st,gnt,sel,busy,pre} got %b want %b", got, e);
      end
    end
  endtask

  // Reset while owner 2 is at counter 5; afterwards search restarts at 0.
  task automatic test_reset_mid_grant();
    logic [9:0] got, e;
    for (int i = 0; i < 6; i++)
      plan(1'b0, 4'b0100, ew(ST_GRANT, 4'b0100, 2'b10, 1'b1, 1'b0));
    plan(1'b1, 4'b0100, ew(ST_IDLE, 4'b0000, 2'b00, 1'b0, 1'b0));
    plan(1'b0, 4'b0110, ew(ST_GRANT, 4'b0010, 2'b01, 1'b1, 1'b0));
    plan(1'b0, 4'b0000, ew(ST_TURN, 4'b0000, 2'b01, 1'b0, 1'b0));
    plan(1'b0, 4'b0000, ew(ST_IDLE, 4'b0000, 2'b01, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      tick(stim_q.pop_front());
      got = observed();
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_mid: {st,gnt,sel,busy,pre} got %b want %b", got, e);
      end
    end
  endtask

  // Owner 1 drops exactly on its timeout cycle with req[2] pending:
  // plain release, no preempt, requester 2 granted after TURN/IDLE.
  task automatic test_drop_on_timeout();
    logic [9:0] got, e;
    logic [3:0] other;
    plan(1'b0, 4'b0010, ew(ST_GRANT, 4'b0010, 2'b01, 1'b1, 1'b0));
    for (int i = 0; i < 7; i++) begin
      // req[2] may or may not be up before the limit; it must not matter.
      other = ($urandom_range(0, 1) == 1) ? 4'b0110 : 4'b0010;
      if (i == 6) other = 4'b0110;
      plan(1'b0, other, ew(ST_GRANT, 4'b0010, 2'b01, 1'b1, 1'b0));
    end
    plan(1'b0, 4'b0100, ew(ST_TURN, 4'b0000, 2'b01, 1'b0, 1'b0));
    plan(1'b0, 4'b0100, ew(ST_IDLE, 4'b0000, 2'b01, 1'b0, 1'b0));
    plan(1'b0, 4'b0100, ew(ST_GRANT, 4'b0100, 2'b10, 1'b1, 1'b0));
    plan(1'b0, 4'b0000, ew(ST_TURN, 4'b0000, 2'b10, 1'b0, 1'b0));
    plan(1'b0, 4'b0000, ew(ST_IDLE, 4'b0000, 2'b10, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      tick(stim_q.pop_front());
      got = observed();
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL drop_timeout: {st,gnt,sel,busy,pre} got %b want %b", got, e);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.req = 4'b0000;
    test_reset();
    test_basic();
    test_rotate_preempt();
    test_lone_hold();
    test_wrap();
    test_reset_mid_grant();
    test_drop_on_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
